// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a one-entry stall hold buffer and a kill state that drops a stale memory response after a redirect
//   clk, reset        : clock, asynchronous active-high reset
//   npc               : next fetch address, taken when pc advances or on flush
//   stall, flush      : decode back-pressure, redirect (flush wins over everything)
//   pc                : current fetch address
//   im_req, im_addr   : instruction-memory request and its address (always pc)
//   im_ack, im_rdata  : one-cycle response pulse and its instruction word
//   instr_d, pc_d, valid_d, adel_d : IF/ID register
//   fetch_cnt         : instructions delivered into IF/ID, wraps
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          ACK_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          npc,
  input  logic                 stall,
  input  logic                 flush,
  output logic [31:0]          pc,
  output logic                 im_req,
  output logic [31:0]          im_addr,
  input  logic                 im_ack,
  input  logic [31:0]          im_rdata,
  output logic [31:0]          instr_d,
  output logic [31:0]          pc_d,
  output logic                 valid_d,
  output logic                 adel_d,
  output logic [ACK_CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

  state_t      state, state_n;
  logic [31:0] hb_instr, hb_pc;
  logic        hb_adel;
  logic        mis;
  logic        ack;
  logic [31:0] ack_instr;
  logic        pc_ld, ifid_ld, ifid_clr, src_hb, hb_ld;

  // A misaligned pc never reaches memory; it completes on the spot as an address-error entry.
  assign mis       = pc[1:0] != 2'b00;
  assign im_req    = state == FETCH && !mis;
  assign im_addr   = pc;
  assign ack       = state == FETCH && (mis || im_ack);
  assign ack_instr = mis ? 32'h0 : im_rdata;

  always_comb begin
    state_n  = state;
    pc_ld    = 1'b0;
    ifid_ld  = 1'b0;
    ifid_clr = 1'b0;
    src_hb   = 1'b0;
    hb_ld    = 1'b0;
    case (state)
      FETCH: begin
        if (flush) begin
          pc_ld    = 1'b1;
          ifid_clr = 1'b1;
          // A request still in flight must have its late response dropped.
          state_n  = (im_req && !im_ack) ? KILL : FETCH;
        end else if (ack && !stall) begin
          ifid_ld = 1'b1;
          pc_ld   = 1'b1;
        end else if (ack) begin
          hb_ld   = 1'b1;
          state_n = HOLD;
        end else begin
          ifid_clr = !stall;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_ld    = 1'b1;
          ifid_clr = 1'b1;
          state_n  = FETCH;
        end else if (!stall) begin
          ifid_ld = 1'b1;
          src_hb  = 1'b1;
          pc_ld   = 1'b1;
          state_n = FETCH;
        end
      end
      KILL: begin
        pc_ld    = flush;
        ifid_clr = flush || !stall;
        // The awaited response retires the dead request even on a fresh redirect.
        state_n  = im_ack ? FETCH : KILL;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      hb_instr  <= 32'h0;
      hb_pc     <= 32'h0;
      hb_adel   <= 1'b0;
      instr_d   <= 32'h0;
      pc_d      <= 32'h0;
      valid_d   <= 1'b0;
      adel_d    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_n;
      if (pc_ld)
        pc <= npc;
      if (hb_ld) begin
        hb_instr <= ack_instr;
        hb_pc    <= pc;
        hb_adel  <= mis;
      end
      if (ifid_ld) begin
        instr_d   <= src_hb ? hb_instr : ack_instr;
        pc_d      <= src_hb ? hb_pc : pc;
        adel_d    <= src_hb ? hb_adel : mis;
        valid_d   <= 1'b1;
        fetch_cnt <= fetch_cnt + ACK_CNT_W'(1);
      end else if (ifid_clr) begin
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a behavioural fetch model
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, im_ack = 1'b0;
  logic [31:0] npc = 32'h0, im_rdata = 32'h0;
  logic [31:0] pc, im_addr, instr_d, pc_d, fetch_cnt;
  logic        im_req, valid_d, adel_d;

  fetch_unit dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .flush(flush),
    .pc(pc), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d), .adel_d(adel_d), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  // model: pc, pending buffered instruction {adel, pc, instr}, drop-next-response flag, IF/ID
  logic [31:0] m_pc, m_instr, m_pcd, m_cnt;
  logic        m_valid, m_adel, m_kill;
  logic [64:0] m_hq[$];

  // memory: accepts a request, answers after 0..2 cycles
  logic        mbusy;
  int          mcnt;
  logic [31:0] maddr;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_cnt = 0;
    m_valid = 0; m_adel = 0; m_kill = 0;
    m_hq.delete();
  endtask

  task automatic deliver(input logic [64:0] w);
    m_adel = w[64]; m_pcd = w[63:32]; m_instr = w[31:0];
    m_valid = 1; m_cnt++;
  endtask

  function automatic logic exp_req();
    return !m_kill && m_hq.size() == 0 && m_pc[1:0] == 2'b00;
  endfunction

  task automatic model_step(input logic s, input logic f, input logic [31:0] n, input logic a, input logic [31:0] d);
    logic req, got, misal;
    logic [64:0] w;
    misal = m_pc[1:0] != 2'b00;
    req = exp_req();
    got = !m_kill && m_hq.size() == 0 && (misal || a);
    w = misal ? {1'b1, m_pc, 32'h0} : {1'b0, m_pc, d};
    if (f) begin
      m_kill = m_kill ? !a : (req && !a);
      m_hq.delete();
      m_pc = n;
      m_valid = 0;
    end else if (m_kill) begin
      if (a) m_kill = 0;
      if (!s) m_valid = 0;
    end else if (m_hq.size() != 0) begin
      if (!s) begin deliver(m_hq.pop_front()); m_pc = n; end
    end else if (got) begin
      if (s) m_hq.push_back(w);
      else begin deliver(w); m_pc = n; end
    end else if (!s) m_valid = 0;
  endtask

  task automatic compare_model();
    chk("pc", pc, m_pc);
    chk("im_req", 32'(im_req), 32'(exp_req()));
    chk("im_addr", im_addr, m_pc);
    chk("valid_d", 32'(valid_d), 32'(m_valid));
    chk("fetch_cnt", fetch_cnt, m_cnt);
    if (m_valid) begin
      chk("instr_d", instr_d, m_instr);
      chk("pc_d", pc_d, m_pcd);
      chk("adel_d", 32'(adel_d), 32'(m_adel));
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic s, input logic f, input logic [31:0] n, input logic a, input logic [31:0] d);
    stall = s; flush = f; npc = n; im_ack = a; im_rdata = d;
    model_step(s, f, n, a, d);
    @(posedge clk);
    #1 compare_model();
    @(negedge clk);
  endtask

  // called at a negedge; checks the asynchronous effect before any clock edge
  task automatic do_reset();
    reset = 1; stall = 0; flush = 0; im_ack = 0;
    #1;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_valid", 32'(valid_d), 0);
    chk("reset_cnt", fetch_cnt, 0);
    model_reset();
    mbusy = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    logic s, f, a;
    logic [31:0] n, d, r;
    @(negedge clk);
    do_reset();
    chk("req_after_reset", 32'(im_req), 1);
    step(0, 0, 32'h3004, 1, 32'h1111_0000);
    chk("seq_pc_d0", pc_d, 32'h3000);
    step(0, 0, 32'h3008, 1, 32'h1111_0004);
    chk("seq_pc_d1", pc_d, 32'h3004);
    step(0, 0, 32'h300C, 1, 32'h1111_0008);
    chk("seq_pc_d2", pc_d, 32'h3008);
    chk("seq_valid", 32'(valid_d), 1);
    chk("seq_cnt", fetch_cnt, 3);

    do_reset();
    step(0, 0, 32'h3004, 1, 32'hAAAA_0000);
    step(1, 0, 32'h3008, 1, 32'hBBBB_0004);
    step(1, 0, 32'h3008, 0, 0);
    step(1, 0, 32'h3008, 0, 0);
    chk("hold_pc", pc, 32'h3004);
    chk("hold_req", 32'(im_req), 0);
    step(0, 0, 32'h3008, 0, 0);
    chk("hold_rel_valid", 32'(valid_d), 1);
    chk("hold_rel_pc_d", pc_d, 32'h3004);
    chk("hold_rel_instr", instr_d, 32'hBBBB_0004);
    chk("hold_rel_addr", im_addr, 32'h3008);
    chk("hold_rel_req", 32'(im_req), 1);

    do_reset();
    step(0, 1, 32'h4180, 0, 0);
    chk("kill_req", 32'(im_req), 0);
    step(0, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    chk("kill_valid", 32'(valid_d), 0);
    chk("kill_next_req", 32'(im_req), 1);
    chk("kill_next_addr", im_addr, 32'h4180);

    do_reset();
    step(0, 0, 32'h3006, 1, 32'h1234_5678);
    chk("adel_noreq", 32'(im_req), 0);
    step(0, 0, 32'h3100, 1, 32'hBAD0_BAD0);
    chk("adel_valid", 32'(valid_d), 1);
    chk("adel_flag", 32'(adel_d), 1);
    chk("adel_pc_d", pc_d, 32'h3006);
    chk("adel_instr", instr_d, 32'h0);

    do_reset();
    step(0, 0, 32'h3004, 1, 32'hAAAA_0000);
    step(1, 0, 32'h3008, 1, 32'hBBBB_0004);
    chk("hold_before_reset", 32'(im_req), 0);
    do_reset();

    step(1, 1, 32'h5000, 1, 32'hCCCC_0000);
    chk("flush_ack_valid", 32'(valid_d), 0);
    chk("flush_ack_pc", pc, 32'h5000);
    chk("flush_ack_nohold", 32'(im_req), 1);
    chk("flush_ack_cnt", fetch_cnt, 0);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      a = 0; d = 0;
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin a = 1; d = {maddr[15:0], ~maddr[15:0]}; mbusy = 0; end
      end else if (im_req) begin
        maddr = im_addr;
        mcnt = $urandom_range(0, 2);
        if (mcnt == 0) begin a = 1; d = {maddr[15:0], ~maddr[15:0]}; end
        else mbusy = 1;
      end else if ($urandom % 8 == 0) begin
        a = 1; d = $urandom;
      end
      s = ($urandom % 4) == 0;
      f = ($urandom % 16) == 0 && !(m_kill && a);
      r = $urandom;
      case ($urandom % 8)
        0: n = m_pc + 32'd2;
        1: n = {r[31:2], 2'b00};
        default: n = m_pc + 32'd4;
      endcase
      step(s, f, n, a, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
